// File: rtl/uart_pkg.sv
// uart_pkg: receiver states, data-width limits and the frame-length clamp shared by the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam logic [3:0] MIN_DATA_BITS = 4'd5;
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return len < MIN_DATA_BITS ? MIN_DATA_BITS : (len > max_len ? max_len : len);
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: received-frame FIFO with registered head output
// Ports: clk/rst (async, active-high); push/wdata write side; pop/rdata read side (rdata is the head, 0 when empty);
//   full/empty status. Simultaneous push and pop is accepted even when full.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_n;
  logic [NW-1:0] count, count_n;
  logic do_push, do_pop;
  assign full = count == NW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count_n = count + NW'(do_push) - NW'(do_pop);
  assign rd_n = rd + AW'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= wdata;
  // The head register loads the incoming word directly when it lands in an otherwise empty FIFO.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      rd <= rd_n;
      wr <= wr + AW'(do_push);
      count <= count_n;
      rdata <= count_n == '0 ? '0 : (count == NW'(do_pop) ? wdata : mem[rd_n]);
    end
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampled UART receiver with majority vote, error/break detection and output FIFO
// Ports: clk_16bd 16x baud clock; rst async active-high; rx asynchronous serial line (idle high);
//   cfg_frame_len/cfg_parity_en/cfg_parity_odd/cfg_stop2 frame format, latched at start detection;
//   m_data/m_valid/m_ready FIFO head handshake; err_parity/err_frame/overrun/break_det one-cycle pulses.
// Define UART_RX_ERR_TAG_EN to keep errored frames in the FIFO, tagged on m_perr/m_ferr.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk_16bd,
  input  logic                     rst,
  input  logic                     rx,
  input  logic [3:0]               cfg_frame_len,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
`ifdef UART_RX_ERR_TAG_EN
  output logic                     m_perr,
  output logic                     m_ferr,
`endif
  output logic                     err_parity,
  output logic                     err_frame,
  output logic                     overrun,
  output logic                     break_det
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] T7 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] T8 = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] T9 = CW'(OVERSAMPLE / 2 + 1);
`ifdef UART_RX_ERR_TAG_EN
  localparam int FW = MAX_DATA_BITS + 2;
`else
  localparam int FW = MAX_DATA_BITS;
`endif
  state_t state, state_n;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [3:0] len, bit_idx;
  logic [MAX_DATA_BITS-1:0] data;
  logic [FW-1:0] wdata, rdata;
  logic rx_s, s7, s8, vote, tap9, wrap, brk;
  logic par_en, odd, stop2, second, par_bit, perr, ferr, fin;
  logic push, pop, full, empty;
  assign rx_s = sync[1];
  assign tap9 = cnt == T9;
  assign wrap = &cnt;
  assign vote = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  // A break is an all-zero frame whose first stop bit is also low.
  assign brk = ferr && !second && data == '0 && !(par_en && par_bit);
  assign m_valid = !empty;
  assign pop = m_valid && m_ready;
  assign m_data = rdata[MAX_DATA_BITS-1:0];
`ifdef UART_RX_ERR_TAG_EN
  assign push = fin && !brk;
  assign wdata = {perr, ferr, data};
  assign m_perr = rdata[FW-1];
  assign m_ferr = rdata[FW-2];
`else
  assign push = fin && !perr && !ferr;
  assign wdata = data;
`endif
  uart_rx_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_16bd), .rst(rst), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rdata), .full(full), .empty(empty)
  );
  always_ff @(posedge clk_16bd or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rx_s ? IDLE : START;
      START:   state_n = tap9 && vote ? IDLE : (wrap ? DATA : START);
      DATA:    state_n = wrap && bit_idx == len ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  state_n = wrap ? STOP : PARITY;
      STOP:    state_n = fin ? (brk ? BREAK : IDLE) : STOP;
      BREAK:   state_n = rx_s && wrap ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  // fin marks the cycle after the last stop-bit vote; the frame is retired there without waiting for wrap.
  always_ff @(posedge clk_16bd or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      cnt <= '0;
      s7 <= 1'b1;
      s8 <= 1'b1;
      len <= MIN_DATA_BITS;
      bit_idx <= '0;
      data <= '0;
      par_en <= 1'b0;
      odd <= 1'b0;
      stop2 <= 1'b0;
      second <= 1'b0;
      par_bit <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      fin <= 1'b0;
      err_parity <= 1'b0;
      err_frame <= 1'b0;
      overrun <= 1'b0;
      break_det <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      cnt <= (state == IDLE || fin || (state == BREAK && !rx_s)) ? '0 : cnt + 1'b1;
      if (cnt == T7) s7 <= rx_s;
      if (cnt == T8) s8 <= rx_s;
      if (state == IDLE && !rx_s) begin
        len <= clamp_len(cfg_frame_len, 4'(MAX_DATA_BITS));
        par_en <= cfg_parity_en;
        odd <= cfg_parity_odd;
        stop2 <= cfg_stop2;
        bit_idx <= '0;
        data <= '0;
        second <= 1'b0;
        par_bit <= 1'b0;
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == DATA && tap9) begin
        data <= data | (MAX_DATA_BITS'(vote) << bit_idx);
        bit_idx <= bit_idx + 4'd1;
      end
      if (state == PARITY && tap9) begin
        par_bit <= vote;
        perr <= (^data ^ vote) != odd;
      end
      if (state == STOP && tap9 && !vote) ferr <= 1'b1;
      if (state == STOP && wrap) second <= 1'b1;
      fin <= state == STOP && tap9 && (!vote || !stop2 || second);
      err_parity <= fin && perr;
      err_frame <= fin && ferr && !brk;
      break_det <= fin && brk;
      overrun <= push && full && !pop;
    end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Parametrised UART receiver running on the 16x baud clock. Supports 5..MAX_DATA_BITS data bits, optional even/odd parity, and 1 or 2 stop bits. Adds majority-vote sampling, false-start rejection, framing/parity/break detection and an output FIFO with a valid/ready handshake. Sits between the pad-level Rx line and the command decoder that consumes received characters.

Parameters:
MAX_DATA_BITS, 9, widest supported data field; sets the m_data width.
OVERSAMPLE, 16, clk_16bd cycles per bit; must be a power of two, >= 8.
FIFO_DEPTH, 4, received-frame FIFO entries; must be a power of two, >= 2.

Ports:
clk_16bd  in  1  16x baud clock
rst  in  1  asynchronous, active-high reset
rx  in  1  serial line, idle high, asynchronous to clk_16bd
cfg_frame_len  in  4  data bits per frame; clamped to 5..MAX_DATA_BITS
cfg_parity_en  in  1  parity bit present
cfg_parity_odd  in  1  1 = odd parity, 0 = even parity
cfg_stop2  in  1  1 = two stop bits, 0 = one stop bit
m_data  out  MAX_DATA_BITS  received data, LSB = first bit on the wire, unused MSBs zero
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data this cycle
err_parity  out  1  one-cycle pulse: parity mismatch
err_frame  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: good frame dropped because the FIFO was full
break_det  out  1  one-cycle pulse: break condition

Behaviour:
- Reset: state IDLE, all counters 0, FIFO empty, synchronizer flops 1; m_valid, m_data and all error pulses 0.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s; add 2 cycles of latency to any rx-relative timing.
- Sample counter: log2(OVERSAMPLE) bits, wraps. Mid-bit taps are OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9 at the default). Bit value is the majority of the three taps, resolved at tap 9.
- cfg_* inputs are latched on start detection and held for the whole frame. Changes mid-frame have no effect.
- States:
  - IDLE: on rx_s = 0, clear the sample counter and go to START.
  - START: at tap 9, vote = 1 means a false start: return to IDLE with no flags. Vote = 0 goes to DATA at counter wrap.
  - DATA: shift in the voted bit at each tap 9. After frame_len bits, go to PARITY if parity is enabled, else to STOP, at wrap.
  - PARITY: XOR of the data bits and the parity bit must be 0 (even) or 1 (odd); a failure is recorded. Go to STOP at wrap.
  - STOP: evaluated at tap 9 of each stop bit.
    - Low stop bit: record a framing error.
    - Second stop bit (cfg_stop2 = 1): sampled only if the first stop bit was high.
    - Frame completion, next cycle after the final stop evaluation:
      - push when there are no errors;
      - pulse err_parity and/or err_frame when errors exist;
      - return to IDLE immediately, without waiting for counter wrap, so back-to-back frames are accepted.
    - Break: data all zero, parity (if enabled) zero, and stop low. Then pulse break_det instead of err_frame and go to BREAK.
  - BREAK: wait for rx_s = 1 for OVERSAMPLE consecutive cycles, then go to IDLE.
- FIFO:
  - Push and pop in the same cycle is legal, including when full.
  - Push when full without a same-cycle pop: the frame is dropped, overrun pulses, and existing contents are kept.
  - m_data is registered and reflects the head entry.
  - Pop on m_valid & m_ready.
- Latency: m_valid rises 2 cycles after the tap-9 evaluation of the final stop bit when the FIFO was empty.
- Reset mid-frame: frame discarded, FIFO flushed, no pulses.

Optional Feature:
UART_RX_ERR_TAG_EN
- Defined:
  - adds outputs m_perr and m_ferr, one bit each, stored per FIFO entry;
  - frames with a parity or framing error are pushed with their tags set;
  - error pulses still fire;
  - break frames are never pushed.
- Undefined: errored frames are dropped and those ports are absent.

Decomposition:
- Package uart_pkg:
  - state enum localparams IDLE, START, DATA, PARITY, STOP, BREAK;
  - MIN_DATA_BITS = 5;
  - a function clamping frame_len.
- Sub-module uart_rx_fifo: parametrised by width and depth, with push/pop/full/empty. The main block instantiates it once.

Test Plan:
- 8N1, frame_len 8, byte 0x5A, m_ready = 1 -> m_data = 0x05A, one m_valid pulse, no error pulses.
- 9 bits, even parity, 2 stop bits, data 0x1A5, parity bit forced wrong -> err_parity pulse only, FIFO stays empty (with UART_RX_ERR_TAG_EN: entry with m_perr = 1).
- rx low for 5 cycles, then high -> START aborts at tap 9, no flags, back in IDLE.
- 8N1, bytes 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back, m_ready = 0 -> FIFO holds 0x01..0x04, overrun pulses once for 0x05. Then m_ready = 1 -> data pops in order.
- rx held low for 20 bit times, then high -> one break_det pulse, no err_frame, no push. Next 0x33 frame is received correctly.
- Line noise: 1-cycle high glitch at tap 8 of each data bit of 0xC3 -> 0xC3 still received via majority vote.
